// File: rtl/i2c_defs.sv
// Shared I2C definitions: widths and target FSM state encodings.
package i2c_defs;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Bus lines plus user-side byte interface of the I2C target.
// Handshake: rx_valid is a one-clk pulse qualifying rx_data; tx_load is a
// one-clk pulse marking the clk on which tx_data was captured (tx_data may
// change after it). There is no back-pressure in either direction.
interface i2c_target_if;
    import i2c_defs::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_out;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_load;
    logic                  busy;
    logic                  dir_write;
    i2c_state_e            state_dbg;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_out, rx_data, rx_valid, tx_load, busy, dir_write, state_dbg
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_out, rx_data, rx_valid, tx_load, busy, dir_write, state_dbg
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizer for SCL/SDA with a history flop for edge, START and
// STOP detection. Flops reset to 1 (idle bus) so reset release is edge-free.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;

    // Synchronize both lines and keep one cycle of history of the synced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_sync_q[1] & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q[1] & scl_hist_q;
    // SDA edges only count as conditions while SCL is high on both samples.
    assign start_det = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, controller-write byte delivery and
// controller-read byte shifting. No clock stretching.
module i2c_target
    import i2c_defs::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR  = 7'h6B,
    parameter logic                  RW_WRITE_VAL = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    i2c_target_if.slave bus
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e            state_q;
    logic [2:0]            cnt_q;
    logic [I2C_BYTE_W-1:0] shift_q;
    logic [I2C_BYTE_W-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_load_q;
    logic                  sda_out_q;
    logic                  busy_q;
    logic                  dir_write_q;
    logic                  ack_drv_q;   // ACK slot: low already driven, next fall releases
    logic                  tx_ack_q;    // controller ACK bit sampled in TX_ACK
    logic [I2C_BYTE_W-1:0] rx_byte;

    // Byte as it will look once the bit being sampled now is shifted in.
    assign rx_byte = {shift_q[I2C_BYTE_W-2:0], sda_s};

    // Protocol FSM; START/STOP override any state, START first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd7;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            dir_write_q <= 1'b0;
            ack_drv_q   <= 1'b0;
            tx_ack_q    <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            if (start_det) begin
                state_q   <= ST_ADDR;
                cnt_q     <= 3'd7;
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else if (stop_det) begin
                state_q   <= ST_IDLE;
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (cnt_q == 3'd0) begin
                                if (rx_byte[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                                    state_q     <= ST_ADDR_ACK;
                                    busy_q      <= 1'b1;
                                    dir_write_q <= (rx_byte[0] == RW_WRITE_VAL);
                                    ack_drv_q   <= 1'b0;
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                end
                            end else begin
                                cnt_q <= cnt_q - 3'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_q) begin
                                sda_out_q <= 1'b0;
                                ack_drv_q <= 1'b1;
                            end else begin
                                ack_drv_q <= 1'b0;
                                cnt_q     <= 3'd7;
                                if (dir_write_q) begin
                                    sda_out_q <= 1'b1;
                                    state_q   <= ST_RX_DATA;
                                end else begin
                                    shift_q   <= bus.tx_data;
                                    tx_load_q <= 1'b1;
                                    sda_out_q <= bus.tx_data[I2C_BYTE_W-1];
                                    state_q   <= ST_TX_DATA;
                                end
                            end
                        end
                    end
                    ST_RX_DATA: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (cnt_q == 3'd0) begin
                                rx_data_q  <= rx_byte;
                                rx_valid_q <= 1'b1;
                                ack_drv_q  <= 1'b0;
                                state_q    <= ST_RX_ACK;
                            end else begin
                                cnt_q <= cnt_q - 3'd1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_q) begin
                                sda_out_q <= 1'b0;
                                ack_drv_q <= 1'b1;
                            end else begin
                                sda_out_q <= 1'b1;
                                ack_drv_q <= 1'b0;
                                cnt_q     <= 3'd7;
                                state_q   <= ST_RX_DATA;
                            end
                        end
                    end
                    ST_TX_DATA: begin
                        // Bit 7 went out on the entry fall; each later fall advances one bit.
                        if (scl_fall) begin
                            if (cnt_q == 3'd0) begin
                                sda_out_q <= 1'b1;
                                state_q   <= ST_TX_ACK;
                            end else begin
                                cnt_q     <= cnt_q - 3'd1;
                                shift_q   <= {shift_q[I2C_BYTE_W-2:0], 1'b0};
                                sda_out_q <= shift_q[I2C_BYTE_W-2];
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            tx_ack_q <= sda_s;
                        end else if (scl_fall) begin
                            if (!tx_ack_q) begin
                                shift_q   <= bus.tx_data;
                                tx_load_q <= 1'b1;
                                sda_out_q <= bus.tx_data[I2C_BYTE_W-1];
                                cnt_q     <= 3'd7;
                                state_q   <= ST_TX_DATA;
                            end else begin
                                sda_out_q <= 1'b1;
                                state_q   <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_out_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_out   = sda_out_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.busy      = busy_q;
    assign bus.dir_write = dir_write_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target with a behavioural controller (SCL = clk/32).
module tb_i2c_target;
    import i2c_defs::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic [7:0] tx_reg = 8'h00;

    int n_cmp = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_src_q[$];

    i2c_target_if bus ();

    assign bus.scl_in  = scl_drv;
    assign bus.sda_in  = sda_drv & bus.sda_out;   // wired-AND open drain
    assign bus.tx_data = tx_reg;

    i2c_target dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Scoreboard / monitor on the inactive edge
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            if (exp_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
        if (bus.tx_load) begin
            tx_cnt++;
            if (tx_src_q.size() != 0) tx_reg = tx_src_q.pop_front();
        end
    end

    // Driver tasks (all start and end in the middle of an SCL low phase, except start_c from idle)
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        sda_drv = 1'b1; wclk(8);
        scl_drv = 1'b1; wclk(8);
        sda_drv = 1'b0; wclk(8);
        scl_drv = 1'b0; wclk(8);
    endtask

    task automatic stop_c();
        sda_drv = 1'b0; wclk(8);
        scl_drv = 1'b1; wclk(8);
        sda_drv = 1'b1; wclk(8);
    endtask

    task automatic bit_c(input logic b, output logic r);
        sda_drv = b;    wclk(8);
        scl_drv = 1'b1; wclk(8);
        r = bus.sda_in; wclk(8);
        scl_drv = 1'b0; wclk(8);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_c(d[i], r);
        bit_c(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack_bit, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, r);
            d[i] = r;
        end
        bit_c(ack_bit, r);
    endtask

    initial begin
        logic ack;
        logic r;
        logic [7:0] d;

        wclk(4);
        chk("rst_sda_out", 32'(bus.sda_out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        wclk(4);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_tx_load", 32'(bus.tx_load), 32'd0);
        chk("rst_dir_write", 32'(bus.dir_write), 32'd0);
        chk("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));

        // 1: write 0xA5 to 0x6B
        rx_cnt = 0;
        exp_q.push_back(8'hA5);
        start_c();
        chk("t1_state_addr", 32'(bus.state_dbg), 32'(ST_ADDR));
        wr_byte(8'hD7, ack);
        chk("t1_addr_ack", 32'(ack), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_dir_write", 32'(bus.dir_write), 32'd1);
        wr_byte(8'hA5, ack);
        chk("t1_data_ack", 32'(ack), 32'd0);
        stop_c();
        chk("t1_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("t1_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("t1_busy_after", 32'(bus.busy), 32'd0);

        // 2: wrong address 0x2A
        rx_cnt = 0;
        start_c();
        wr_byte(8'h55, ack);
        chk("t2_nack", 32'(ack), 32'd1);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        chk("t2_wait_stop", 32'(bus.state_dbg), 32'(ST_WAIT_STOP));
        wr_byte(8'h12, ack);
        chk("t2_data_nack", 32'(ack), 32'd1);
        stop_c();
        chk("t2_rx_cnt", 32'(rx_cnt), 32'd0);
        chk("t2_idle", 32'(bus.state_dbg), 32'(ST_IDLE));

        // 3: read 0x3C (ACK) then 0xC3 (NACK)
        tx_cnt = 0;
        tx_reg = 8'h3C;
        tx_src_q.push_back(8'hC3);
        tx_src_q.push_back(8'h00);
        start_c();
        wr_byte(8'hD6, ack);
        chk("t3_addr_ack", 32'(ack), 32'd0);
        chk("t3_dir_write", 32'(bus.dir_write), 32'd0);
        rd_byte(1'b0, d);
        chk("t3_byte0", 32'(d), 32'h3C);
        rd_byte(1'b1, d);
        chk("t3_byte1", 32'(d), 32'hC3);
        chk("t3_released", 32'(bus.sda_out), 32'd1);
        chk("t3_wait_stop", 32'(bus.state_dbg), 32'(ST_WAIT_STOP));
        chk("t3_tx_cnt", 32'(tx_cnt), 32'd2);
        stop_c();
        chk("t3_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        tx_src_q.delete();

        // 4: write 2 bytes, repeated START, read 1 byte
        rx_cnt = 0;
        tx_cnt = 0;
        tx_reg = 8'h5A;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        start_c();
        wr_byte(8'hD7, ack);
        chk("t4_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'h11, ack);
        chk("t4_d0_ack", 32'(ack), 32'd0);
        wr_byte(8'h22, ack);
        chk("t4_d1_ack", 32'(ack), 32'd0);
        start_c();
        chk("t4_rs_state", 32'(bus.state_dbg), 32'(ST_ADDR));
        chk("t4_rs_busy", 32'(bus.busy), 32'd0);
        wr_byte(8'hD6, ack);
        chk("t4_raddr_ack", 32'(ack), 32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd1);
        chk("t4_dir_write", 32'(bus.dir_write), 32'd0);
        rd_byte(1'b1, d);
        chk("t4_rd", 32'(d), 32'h5A);
        stop_c();
        chk("t4_rx_cnt", 32'(rx_cnt), 32'd2);
        chk("t4_tx_cnt", 32'(tx_cnt), 32'd1);

        // 5: STOP after 4 data bits
        rx_cnt = 0;
        start_c();
        wr_byte(8'hD7, ack);
        chk("t5_addr_ack", 32'(ack), 32'd0);
        bit_c(1'b1, r);
        bit_c(1'b0, r);
        bit_c(1'b1, r);
        bit_c(1'b1, r);
        stop_c();
        wclk(4);
        chk("t5_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("t5_sda_out", 32'(bus.sda_out), 32'd1);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_rx_cnt", 32'(rx_cnt), 32'd0);

        // 6: reset while the target drives the address ACK
        start_c();
        for (int i = 7; i >= 0; i--) bit_c(((8'hD7 >> i) & 8'h01) != 0, r);
        sda_drv = 1'b1; wclk(8);
        scl_drv = 1'b1; wclk(4);
        chk("t6_ack_driven", 32'(bus.sda_out), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", 32'(bus.sda_out), 32'd1);
        chk("t6_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("t6_busy", 32'(bus.busy), 32'd0);
        wclk(4);
        rst_n = 1'b1;
        wclk(8);
        rx_cnt = 0;
        exp_q.push_back(8'h77);
        start_c();
        wr_byte(8'hD7, ack);
        chk("t6_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'h77, ack);
        chk("t6_data_ack", 32'(ack), 32'd0);
        stop_c();
        chk("t6_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        wclk(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
